fmt_switch_sequencer: RTL
=========================

// Module: fmt_switch_sequencer
// PURPOSE
//  Upstream control stage for the audio bit-clock selector. Accepts a format code from the
//  host/MCU interface over a valid/ready handshake and validates it against the supported
//  table. For a new code it mutes output and parks the selector on code 8'hFF, then applies
//  the new code with a clean next strobe. It unmutes after a settle time.
//  Drives the selector's data_in (sel_code) and next (sel_next) inputs.
// PARAMETERS
//  MUTE_CYC    64    cycles mute held before the selector is touched (>=1)
//  NEXT_W      4     width in cycles of each sel_next high pulse (>=1)
//  GAP_CYC     16    sel_next low cycles between the park and apply strobes (>=1)
//  SETTLE_CYC  1024  cycles after the apply strobe before unmute (>=1)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-low
//  fmt_code     in   8  requested format code (selector encoding; 8'hFF = stop)
//  fmt_valid    in   1  request valid
//  fmt_ready    out  1  high only in IDLE; transfer when fmt_valid & fmt_ready
//  sel_code     out  8  to selector data_in; stable whenever sel_next is high
//  sel_next     out  1  to selector next; selector latches on rising edge
//  mute         out  1  high = downstream DAC path muted
//  busy         out  1  high while a sequence is in progress
//  fmt_err      out  1  one-cycle pulse: unsupported code accepted and dropped
//  active_code  out  8  last successfully applied code
// BEHAVIOUR
//  Reset (async, rst=0): sel_code=8'hFF, sel_next=0, mute=1, busy=0, fmt_err=0,
//   active_code=8'hFF, fmt_ready=1, FSM=IDLE, counters=0. Mid-sequence reset aborts at once.
//  Supported codes: 00,20,40,04,24,44,01,21,41,02,22,42,03,23,43,05,25,45 (hex), FF.
//  FSM: IDLE -> MUTE -> PARK -> APPLY -> SETTLE -> IDLE. Accept cycle = T.
//   IDLE: fmt_ready=1. On transfer:
//    - unsupported code: fmt_err=1 at T+1 only; stay IDLE; all other outputs unchanged.
//    - code==active_code: no sequence; stay IDLE (no error).
//    - otherwise latch code; busy=1, mute=1 from T+1.
//   MUTE: MUTE_CYC cycles (T+1..T+MUTE_CYC).
//   PARK: 1 setup cycle with sel_code=FF, then NEXT_W cycles with sel_next=1, then
//    GAP_CYC cycles with sel_next=0. sel_code holds FF throughout.
//   APPLY: 1 setup cycle with sel_code=new, then NEXT_W cycles with sel_next=1.
//    Skipped if the new code is FF (stop): PARK -> IDLE, mute stays 1, active_code=FF.
//   SETTLE: SETTLE_CYC cycles with sel_next=0.
//    Exit: active_code=new, busy=0, mute=0, FSM=IDLE.
//  sel_code never changes while sel_next=1 or in the cycle before sel_next rises.
//  Requests presented while busy are not accepted (ready low); the requester holds valid.
//  A single down-counter sized $clog2(max param)+1 bits is reloaded at each state
//   entry. There is no wrap-around: the count terminates at zero.
//  All outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  DSD_FMT_EN defined: 8'h80 (DSD) is a supported code and is sequenced like any other.
//  DSD_FMT_EN undefined: 8'h80 is unsupported; it yields an fmt_err pulse and no sequence.
// TESTING
//  1 Assert rst=0 mid-run -> sel_code=FF, sel_next=0, mute=1, busy=0, ready=1 immediately.
//  2 Defaults, from IDLE (active=FF), send 8'h01 at T -> mute/busy at T+1; sel_code=FF at T+65;
//    sel_next=1 at T+66..T+69; sel_code=01 at T+86; sel_next=1 at T+87..T+90;
//    mute=0, ready=1, active=01 at T+1115.
//  3 Send 8'h07 -> fmt_err=1 at T+1 only; sel_next never rises; mute unchanged.
//  4 With active=01, send 8'h01 -> no sel_next activity, busy stays 0; then send 8'hFF ->
//    park strobe only, mute stays 1, active=FF.
//  5 Send 8'h45, apply rst=0 during SETTLE, release, send 8'h02 -> full clean sequence;
//    active=02.
//  6 Send 8'h80: with DSD_FMT_EN -> full sequence, active=80; without -> fmt_err pulse.

Source files
------------

// File: rtl/fmt_switch_sequencer.sv
// Format-switch sequencer: mute, park the bit-clock selector on FF, apply the new code, settle, unmute.
// Optional DSD support (code 8'h80) is enabled by defining DSD_FMT_EN.
module fmt_switch_sequencer #(
    parameter int MUTE_CYC   = 64,
    parameter int NEXT_W     = 4,
    parameter int GAP_CYC    = 16,
    parameter int SETTLE_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fmt_code,
    input  logic       fmt_valid,
    output logic       fmt_ready,
    output logic [7:0] sel_code,
    output logic       sel_next,
    output logic       mute,
    output logic       busy,
    output logic       fmt_err,
    output logic [7:0] active_code
);

    localparam int MAX_A = (MUTE_CYC > NEXT_W) ? MUTE_CYC : NEXT_W;
    localparam int MAX_B = (GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC;
    localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXP) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t MUTE_LD   = cnt_t'(MUTE_CYC - 1);
    localparam cnt_t NEXT_LD   = cnt_t'(NEXT_W - 1);
    localparam cnt_t GAP_LD    = cnt_t'(GAP_CYC - 1);
    localparam cnt_t SETTLE_LD = cnt_t'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUTE,
        PARK_SU,
        PARK_HI,
        PARK_GAP,
        APPLY_SU,
        APPLY_HI,
        SETTLE
    } state_t;

    state_t     state, state_d;
    cnt_t       cnt, cnt_d;
    logic [7:0] new_code, new_d;
    logic [7:0] sel_code_d, active_d;
    logic       mute_d, err_d, sel_next_d, busy_d, ready_d;

    function automatic logic supported(input logic [7:0] c);
`ifdef DSD_FMT_EN
        if (c == 8'h80) return 1'b1;
`endif
        return (c == 8'hFF) ||
               ((c[7:4] inside {4'h0, 4'h2, 4'h4}) && (c[3:0] <= 4'h5));
    endfunction

    always_comb begin
        state_d    = state;
        cnt_d      = (cnt == '0) ? cnt : cnt - cnt_t'(1);
        new_d      = new_code;
        sel_code_d = sel_code;
        active_d   = active_code;
        mute_d     = mute;
        err_d      = 1'b0;
        case (state)
            IDLE: begin
                if (fmt_valid) begin
                    if (!supported(fmt_code)) begin
                        err_d = 1'b1;
                    end else if (fmt_code != active_code) begin
                        new_d   = fmt_code;
                        state_d = MUTE;
                        cnt_d   = MUTE_LD;
                        mute_d  = 1'b1;
                    end
                end
            end
            MUTE: if (cnt == '0) begin
                state_d    = PARK_SU;
                cnt_d      = '0;
                sel_code_d = 8'hFF;
            end
            PARK_SU: begin
                state_d = PARK_HI;
                cnt_d   = NEXT_LD;
            end
            PARK_HI: if (cnt == '0) begin
                state_d = PARK_GAP;
                cnt_d   = GAP_LD;
            end
            // A stop request ends after the park strobe, still muted.
            PARK_GAP: if (cnt == '0) begin
                if (new_code == 8'hFF) begin
                    state_d  = IDLE;
                    active_d = 8'hFF;
                end else begin
                    state_d    = APPLY_SU;
                    cnt_d      = '0;
                    sel_code_d = new_code;
                end
            end
            APPLY_SU: begin
                state_d = APPLY_HI;
                cnt_d   = NEXT_LD;
            end
            APPLY_HI: if (cnt == '0) begin
                state_d = SETTLE;
                cnt_d   = SETTLE_LD;
            end
            SETTLE: if (cnt == '0) begin
                state_d  = IDLE;
                active_d = new_code;
                mute_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        sel_next_d = (state_d == PARK_HI) || (state_d == APPLY_HI);
        busy_d     = (state_d != IDLE);
        ready_d    = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            new_code    <= 8'hFF;
            sel_code    <= 8'hFF;
            sel_next    <= 1'b0;
            mute        <= 1'b1;
            busy        <= 1'b0;
            fmt_err     <= 1'b0;
            active_code <= 8'hFF;
            fmt_ready   <= 1'b1;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            new_code    <= new_d;
            sel_code    <= sel_code_d;
            sel_next    <= sel_next_d;
            mute        <= mute_d;
            busy        <= busy_d;
            fmt_err     <= err_d;
            active_code <= active_d;
            fmt_ready   <= ready_d;
        end
    end

endmodule
